amm_simple_arbiter: RTL and testbench
=====================================

// Module: amm_simple_arbiter
//
// PURPOSE
//  2-to-1 Avalon-MM arbiter: shares one slave interface between two masters, complementing the
//  address demux on the opposite side of the bus fabric. Round-robin fairness per transfer; routes
//  pipelined read responses back to the issuing master via an in-order ID FIFO.
//  Sits between CPU/DMA-style masters and a shared register/memory slave.
//
// PARAMETERS
//  MAX_PENDING  4   max outstanding (issued, not yet returned) reads; power of 2, >= 2
//  PEND_W       $clog2(MAX_PENDING)+1  width of pending_cnt_o (derived, do not override)
//
// PORTS
//  clk_i         in   1       system clock
//  rst_i         in   1       asynchronous reset, active-high
//  master_if[0]  if   avalon  requester 0 (arbiter acts as its slave)
//  master_if[1]  if   avalon  requester 1 (arbiter acts as its slave)
//  slave_if      if   avalon  shared slave (arbiter acts as its master)
//  pending_cnt_o out  PEND_W  reads outstanding in ID FIFO
//  err_o         out  1       sticky: slave readdatavalid arrived with ID FIFO empty
//
// BEHAVIOUR
//  - req[x] = master_if[x].read | master_if[x].write. Done = slave_if.(read|write) & !waitrequest.
//  - FSM states (registered): IDLE, OWN0, OWN1.
//    IDLE -> OWN0 if req[0]; else -> OWN1 if req[1]; else stay.
//    OWNx -> OWN(1-x) when req[1-x] & (!req[x] | done); else stay. Never returns to IDLE except reset.
//  - Grant is registered: a request arriving to an unowned port is forwarded to slave 1 cycle later
//    at earliest; an owner's back-to-back requests forward with 0 added latency.
//  - Owner forwarding: slave address/writedata/write/read = owner's; non-owner: read=write=0 seen.
//  - waitrequest: owner gets slave_if.waitrequest; non-owner gets 1. Owner's read when FIFO full:
//    slave_if.read forced 0, owner waitrequest forced 1 (full blocks even if pop in same cycle).
//  - Read tracking: on done & read push owner ID; on slave readdatavalid pop ID; master[ID]
//    readdatavalid=1, other 0. readdata broadcast to both masters. Simultaneous push+pop: count
//    unchanged. Writes untracked (no response).
//  - readdatavalid with empty FIFO: dropped (neither master sees it), err_o set until reset.
//  - A switch of owner never occurs while owner holds an un-accepted command (Avalon hold rule).
//  - Reset (any time, incl. mid-transfer): state IDLE, FIFO empty, pending_cnt_o=0, err_o=0;
//    all master waitrequest=1, slave read=write=0, master readdatavalid=0. Responses to reads
//    issued before reset count as strays (err_o).
//  - Combinational paths: slave waitrequest -> master waitrequest; slave readdatavalid/readdata
//    -> master readdatavalid/readdata (zero latency).
//
// TESTING
//  1 Reset, M0 reads addr 0x010, slave wait=0, rdv 2 cycles later data 0xA5 -> slave sees read
//    at cycle 1, M0 gets rdv+0xA5, M1 rdv stays 0, pending_cnt 1 -> 0.
//  2 M0 and M1 both hold write continuously, slave wait=0 -> writes alternate 0,1,0,1 after
//    first grant to M0; non-owner waitrequest=1 every cycle it is not forwarded.
//  3 Owner M1 read with slave wait=1 for 3 cycles while M0 requests -> owner stays OWN1 until
//    accepted, then OWN0 next cycle; M1 command stable throughout.
//  4 MAX_PENDING=4, M0 issues 5 reads, slave withholds rdv -> 5th: slave read=0, M0 wait=1,
//    pending_cnt=4; one rdv returns -> 5th issues next cycle, pending back to 4.
//  5 Interleaved reads M0,M1,M0 with rdv data 0x11,0x22,0x33 -> M0 gets 0x11,0x33, M1 gets 0x22.
//  6 Stray slave rdv with FIFO empty -> no master rdv, err_o=1 sticky; assert rst_i mid-read
//    -> all outputs at reset values immediately, err_o=0.

Source files
------------

// File: rtl/amm_simple_arbiter.sv
// amm_simple_arbiter
// 2-to-1 Avalon-MM arbiter. Two masters share one slave with round-robin
// ownership per transfer. Pipelined read responses are steered back to the
// issuing master through an in-order FIFO of master IDs.
module amm_simple_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_PENDING = 4,
   parameter int unsigned PEND_W      = $clog2(MAX_PENDING) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // requester 0
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   output logic              m0_waitrequest,
   // requester 1
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic              m1_waitrequest,
   // shared slave
   output logic [ADDR_W-1:0] s_address,
   output logic              s_read,
   output logic              s_write,
   output logic [DATA_W-1:0] s_writedata,
   input  logic [DATA_W-1:0] s_readdata,
   input  logic              s_readdatavalid,
   input  logic              s_waitrequest,
   // status
   output logic [PEND_W-1:0] pending_cnt_o,
   output logic              err_o
);

   localparam int unsigned PTR_W = $clog2(MAX_PENDING);

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic              req0;
   logic              req1;
   logic              done;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              head_id;

   logic [MAX_PENDING-1:0] id_mem;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PEND_W-1:0] cnt;

   assign req0       = m0_read | m0_write;
   assign req1       = m1_read | m1_write;
   assign fifo_full  = (cnt == PEND_W'(MAX_PENDING));
   assign fifo_empty = (cnt == '0);
   assign done       = (s_read | s_write) & ~s_waitrequest;
   assign push       = done & s_read;
   assign pop        = s_readdatavalid & ~fifo_empty;
   assign head_id    = id_mem[rd_ptr];

   // Responses pass through combinationally; only the steering is registered.
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = pop & ~head_id;
   assign m1_readdatavalid = pop & head_id;
   assign pending_cnt_o    = cnt;

   // Ownership state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Round-robin hand-over, only once the owner's command has been accepted
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req0)      state_nxt = OWN0;
            else if (req1) state_nxt = OWN1;
         end
         OWN0: if (req1 && (!req0 || done)) state_nxt = OWN1;
         OWN1: if (req0 && (!req1 || done)) state_nxt = OWN0;
         default: state_nxt = IDLE;
      endcase
   end

   // Forward the owner's command; a read with a full ID FIFO is stalled
   always_comb begin
      s_address      = '0;
      s_writedata    = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      case (state)
         OWN0: begin
            s_address      = m0_address;
            s_writedata    = m0_writedata;
            s_read         = m0_read & ~fifo_full;
            s_write        = m0_write;
            m0_waitrequest = s_waitrequest | (m0_read & fifo_full);
         end
         OWN1: begin
            s_address      = m1_address;
            s_writedata    = m1_writedata;
            s_read         = m1_read & ~fifo_full;
            s_write        = m1_write;
            m1_waitrequest = s_waitrequest | (m1_read & fifo_full);
         end
         default: ;
      endcase
   end

   // In-order FIFO of the master ID for every accepted read
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         id_mem <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            id_mem[wr_ptr] <= (state == OWN1);
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Sticky flag for a response that matches no outstanding read
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                               err_o <= 1'b0;
      else if (s_readdatavalid && fifo_empty)  err_o <= 1'b1;
   end

endmodule

// File: tb/tb_amm_simple_arbiter.sv
// tb_amm_simple_arbiter
// Randomized bench: two Avalon masters that hold commands until accepted and
// a random slave, checked every cycle against a queue-based transfer model.
module tb_amm_simple_arbiter;

   localparam int MP = 4;
   localparam int PW = $clog2(MP) + 1;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] m_addr  [2];
   logic [31:0] m_wdata [2];
   logic        m_rd    [2];
   logic        m_wr    [2];

   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_rdv, m1_rdv, m0_wait, m1_wait;

   logic [31:0] s_addr, s_wdata, s_rdata;
   logic        s_rd, s_wr, s_rdv, s_wait;
   logic [PW-1:0] pend;
   logic        err;

   amm_simple_arbiter #(.MAX_PENDING(MP)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .m0_address       (m_addr[0]),
      .m0_read          (m_rd[0]),
      .m0_write         (m_wr[0]),
      .m0_writedata     (m_wdata[0]),
      .m0_readdata      (m0_rdata),
      .m0_readdatavalid (m0_rdv),
      .m0_waitrequest   (m0_wait),
      .m1_address       (m_addr[1]),
      .m1_read          (m_rd[1]),
      .m1_write         (m_wr[1]),
      .m1_writedata     (m_wdata[1]),
      .m1_readdata      (m1_rdata),
      .m1_readdatavalid (m1_rdv),
      .m1_waitrequest   (m1_wait),
      .s_address        (s_addr),
      .s_read           (s_rd),
      .s_write          (s_wr),
      .s_writedata      (s_wdata),
      .s_readdata       (s_rdata),
      .s_readdatavalid  (s_rdv),
      .s_waitrequest    (s_wait),
      .pending_cnt_o    (pend),
      .err_o            (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: current owner (-1 = none yet), outstanding read IDs, sticky error
   int owner;
   int idq[$];
   bit merr;

   // master stimulus state
   bit          act  [2];
   bit          isrd [2];

   // traffic mix for the current phase (percentages)
   int req_pct, rd_pct, wait_pct, rdv_pct;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic run_cycle();
      bit full, ex_rd, ex_wr, done;
      bit ex_wait [2];
      bit ex_rdv  [2];
      bit req     [2];
      @(negedge clk);
      for (int x = 0; x < 2; x++) begin
         if (!act[x] && $urandom_range(99) < req_pct) begin
            act[x]     = 1'b1;
            isrd[x]    = ($urandom_range(99) < rd_pct);
            m_addr[x]  = $urandom;
            m_wdata[x] = $urandom;
         end
         m_rd[x] = act[x] & isrd[x];
         m_wr[x] = act[x] & ~isrd[x];
      end
      s_wait  = ($urandom_range(99) < wait_pct);
      s_rdv   = ($urandom_range(99) < rdv_pct);
      s_rdata = $urandom;
      #1;
      full       = (idq.size() == MP);
      ex_rd      = 1'b0;
      ex_wr      = 1'b0;
      ex_wait[0] = 1'b1;
      ex_wait[1] = 1'b1;
      ex_rdv[0]  = 1'b0;
      ex_rdv[1]  = 1'b0;
      if (owner >= 0) begin
         ex_rd          = m_rd[owner] && !full;
         ex_wr          = m_wr[owner];
         ex_wait[owner] = s_wait || (m_rd[owner] && full);
      end
      if (s_rdv && idq.size() > 0) ex_rdv[idq[0]] = 1'b1;

      check("s_read",  s_rd, ex_rd);
      check("s_write", s_wr, ex_wr);
      if (owner >= 0 && (ex_rd || ex_wr)) begin
         check("s_address",   s_addr,  m_addr[owner]);
         check("s_writedata", s_wdata, m_wdata[owner]);
      end
      check("m0_wait", m0_wait, ex_wait[0]);
      check("m1_wait", m1_wait, ex_wait[1]);
      check("m0_rdv",  m0_rdv,  ex_rdv[0]);
      check("m1_rdv",  m1_rdv,  ex_rdv[1]);
      check("m0_rdata", m0_rdata, s_rdata);
      check("m1_rdata", m1_rdata, s_rdata);
      check("pending", pend, idq.size());
      check("err",     err,  merr);

      @(posedge clk);
      done   = (ex_rd || ex_wr) && !s_wait;
      req[0] = m_rd[0] | m_wr[0];
      req[1] = m_rd[1] | m_wr[1];
      if (s_rdv) begin
         if (idq.size() > 0) void'(idq.pop_front());
         else                merr = 1'b1;
      end
      if (done && ex_rd) idq.push_back(owner);
      if (owner < 0) begin
         if (req[0])      owner = 0;
         else if (req[1]) owner = 1;
      end else if (req[1-owner] && (!req[owner] || done)) begin
         owner = 1 - owner;
      end
      for (int x = 0; x < 2; x++)
         if (act[x] && !ex_wait[x]) act[x] = 1'b0;
   endtask

   // Reset with traffic live: outputs must drop to reset values at once,
   // and a concurrent slave response must be swallowed.
   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      s_rdv = 1'b1;
      #1;
      check("rst_m0_wait", m0_wait, 1'b1);
      check("rst_m1_wait", m1_wait, 1'b1);
      check("rst_s_read",  s_rd,    1'b0);
      check("rst_s_write", s_wr,    1'b0);
      check("rst_m0_rdv",  m0_rdv,  1'b0);
      check("rst_m1_rdv",  m1_rdv,  1'b0);
      check("rst_pending", pend,    0);
      check("rst_err",     err,     1'b0);
      owner = -1;
      idq.delete();
      merr  = 1'b0;
      for (int x = 0; x < 2; x++) begin
         act[x]  = 1'b0;
         m_rd[x] = 1'b0;
         m_wr[x] = 1'b0;
      end
      s_rdv = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_phase(input int rq, input int rd, input int wt, input int rv, input int n);
      req_pct  = rq;
      rd_pct   = rd;
      wait_pct = wt;
      rdv_pct  = rv;
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   initial begin
      rst     = 1'b1;
      s_wait  = 1'b0;
      s_rdv   = 1'b0;
      s_rdata = '0;
      for (int x = 0; x < 2; x++) begin
         m_addr[x]  = '0;
         m_wdata[x] = '0;
         m_rd[x]    = 1'b0;
         m_wr[x]    = 1'b0;
      end
      repeat (2) @(posedge clk);
      do_reset();

      // mixed traffic, with a reset dropped in mid-stream
      run_phase(60, 50, 30, 30, 250);
      do_reset();
      run_phase(60, 50, 30, 30, 250);
      do_reset();

      // both masters streaming writes: strict alternation
      run_phase(100, 0, 0, 0, 100);
      do_reset();

      // read-heavy with scarce responses: FIFO full, stall, pop-and-refill
      run_phase(100, 100, 20, 10, 400);
      do_reset();

      // busy slave, frequent responses (including strays)
      run_phase(80, 70, 50, 40, 400);
      do_reset();
      run_phase(90, 90, 10, 25, 200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
